victim_wb_buffer: RTL and testbench

- Sits between DCache2Way and the SDRAM controller port.
- Absorbs dirty-line words from the cache's non-blocking victim writeback (vwb_*) port into a FIFO and drains them to SDRAM.
- Arbitrates the SDRAM port between those drains and the cache's own fill/write traffic (m_*).
- Guarantees read-after-writeback ordering: any m_* access whose word address matches a buffered victim word waits until that word has reached SDRAM.

---
 rtl/victim_wb_buffer.sv | 177 +++++++++++++++++
 tb/tb_victim_wb_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_wb_buffer.sv
// Victim writeback buffer between DCache2Way and the SDRAM controller port.
// Dirty-line words from the cache's victim port are queued in a small FIFO and
// drained to SDRAM, while the cache's own fill/write traffic shares the same
// SDRAM port. Any cache access whose word address matches a buffered (or
// about-to-be-buffered) victim word is held off until that word reaches SDRAM.
module victim_wb_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 19
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // victim writeback port
    input  logic [AW-1:0]           vwb_addr,
    input  logic [15:0]             vwb_data_out,
    input  logic [1:0]              vwb_bytesel,
    input  logic                    vwb_wr_en,
    input  logic                    vwb_access,
    output logic                    vwb_ack,
    // cache fill/write port
    input  logic [AW-1:0]           m_addr,
    input  logic [15:0]             m_data_out,
    input  logic [1:0]              m_bytesel,
    input  logic                    m_wr_en,
    input  logic                    m_access,
    output logic [15:0]             m_data_in,
    output logic                    m_ack,
    // SDRAM controller port
    output logic [AW-1:0]           s_addr,
    output logic [15:0]             s_data_out,
    output logic [1:0]              s_bytesel,
    output logic                    s_wr_en,
    output logic                    s_access,
    input  logic [15:0]             s_data_in,
    input  logic                    s_ack,
    // status
    output logic [$clog2(DEPTH):0]  wb_count,
    output logic                    wb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_M = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [1:0]    fifo_be   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;

    logic enq;
    logic deq;
    logic fifo_hit;
    logic hazard;
    logic serve_m;
    logic start_drain;

    // A slot is only reused once count says so; a pop on the same edge does not help.
    assign enq = vwb_access && vwb_wr_en && !vwb_ack && (wb_count < FULL);
    assign deq = (state == DRAIN) && s_ack;

    // Compare the cache address against every live FIFO slot (age below count).
    always_comb begin
        // NOTE: give every combinational output a value before any condition, or a latch is inferred.
        fifo_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(PW'(i) - rd_ptr)} < wb_count) && (fifo_addr[i] == m_addr)) begin
                fifo_hit = 1'b1;
            end
        end
    end

    // The victim word still waiting for its accept also counts as buffered.
    assign hazard = m_access &&
                    (fifo_hit || (vwb_access && !vwb_ack && (vwb_addr == m_addr)));

    // Arbitration in IDLE: full buffer first, then a clean cache request, then any drain.
    assign serve_m     = m_access && !m_ack && !hazard;
    assign start_drain = (wb_count == FULL) || (!serve_m && (wb_count != '0));

    assign wb_empty = (wb_count == '0) && (state != DRAIN);

    // FIFO payload storage, written at the tail on every accepted victim word.
    // NOTE: payload storage has no reset; pointers and count alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= vwb_addr;
            fifo_data[wr_ptr] <= vwb_data_out;
            fifo_be[wr_ptr]   <= vwb_bytesel;
        end
    end

    // Pointers, occupancy and the victim accept pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wb_count <= '0;
            vwb_ack  <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            vwb_ack <= enq;
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   wb_count <= wb_count + 1'b1;
                2'b01:   wb_count <= wb_count - 1'b1;
                default: wb_count <= wb_count;
            endcase
        end
    end

    // SDRAM port sequencer: issue one transaction from IDLE and hold it until s_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            s_addr     <= '0;
            s_data_out <= '0;
            s_bytesel  <= '0;
            s_wr_en    <= 1'b0;
            s_access   <= 1'b0;
            m_data_in  <= '0;
            m_ack      <= 1'b0;
        end else begin
            m_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_drain) begin
                        state      <= DRAIN;
                        s_addr     <= fifo_addr[rd_ptr];
                        s_data_out <= fifo_data[rd_ptr];
                        s_bytesel  <= fifo_be[rd_ptr];
                        s_wr_en    <= 1'b1;
                        s_access   <= 1'b1;
                    end else if (serve_m) begin
                        state      <= SERVE_M;
                        s_addr     <= m_addr;
                        s_data_out <= m_data_out;
                        s_bytesel  <= m_bytesel;
                        s_wr_en    <= m_wr_en;
                        s_access   <= 1'b1;
                    end
                end
                SERVE_M: begin
                    if (s_ack) begin
                        state    <= IDLE;
                        s_access <= 1'b0;
                        m_ack    <= 1'b1;
                        if (!s_wr_en) begin
                            m_data_in <= s_data_in;
                        end
                    end
                end
                DRAIN: begin
                    if (s_ack) begin
                        state    <= IDLE;
                        s_access <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    s_access <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Self-checking bench for victim_wb_buffer: random victim/cache traffic against a
// reactive SDRAM model, with a queue-and-memory reference model of the buffer.
module tb_victim_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int AW     = 19;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int K_NONE  = 0;
    localparam int K_DRAIN = 1;
    localparam int K_M     = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } word_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic [1:0]    be;
    } req_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] vwb_addr = '0;
    logic [15:0]   vwb_data_out = '0;
    logic [1:0]    vwb_bytesel = '0;
    logic          vwb_wr_en = 1'b0;
    logic          vwb_access = 1'b0;
    logic          vwb_ack;
    logic [AW-1:0] m_addr = '0;
    logic [15:0]   m_data_out = '0;
    logic [1:0]    m_bytesel = '0;
    logic          m_wr_en = 1'b0;
    logic          m_access = 1'b0;
    logic [15:0]   m_data_in;
    logic          m_ack;
    logic [AW-1:0] s_addr;
    logic [15:0]   s_data_out;
    logic [1:0]    s_bytesel;
    logic          s_wr_en;
    logic          s_access;
    logic [15:0]   s_data_in = '0;
    logic          s_ack = 1'b0;
    logic [CW-1:0] wb_count;
    logic          wb_empty;

    always #5 clk = ~clk;

    victim_wb_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vwb_addr(vwb_addr), .vwb_data_out(vwb_data_out), .vwb_bytesel(vwb_bytesel),
        .vwb_wr_en(vwb_wr_en), .vwb_access(vwb_access), .vwb_ack(vwb_ack),
        .m_addr(m_addr), .m_data_out(m_data_out), .m_bytesel(m_bytesel),
        .m_wr_en(m_wr_en), .m_access(m_access), .m_data_in(m_data_in), .m_ack(m_ack),
        .s_addr(s_addr), .s_data_out(s_data_out), .s_bytesel(s_bytesel),
        .s_wr_en(s_wr_en), .s_access(s_access), .s_data_in(s_data_in), .s_ack(s_ack),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Reference model state
    word_t        q[$];           // words accepted but not yet written to SDRAM, oldest first
    word_t        dq_vwb[$];      // directed victim requests waiting to be presented
    req_t         dq_m[$];        // directed cache requests waiting to be presented
    logic [15:0]  ref_mem[int];   // memory as the specification says it should end up
    logic [15:0]  sdram_mem[int]; // memory as actually written through the SDRAM port
    word_t        vwb_cur;
    req_t         m_cur;

    bit  gen_en = 0;
    int  vwb_rate = 30;
    int  m_rate = 20;
    int  lat_min = 0;
    int  lat_max = 4;

    bit  txn_active = 0;
    bit  txn_is_m = 0;
    bit  acking = 0;
    int  lat = 0;
    logic [AW+18:0] txn_bits = '0;
    logic [15:0] m_exp_rdata = '0;
    logic [15:0] last_rd = '0;
    bit  exp_vwb_ack = 0;
    bit  exp_m_ack = 0;
    int  exp_issue = K_NONE;

    function automatic logic [15:0] init_val(input int a);
        return a[15:0] ^ 16'h5a5a;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [15:0] sdram_rd(input int a);
        if (sdram_mem.exists(a)) return sdram_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'(32'h08010 + $urandom_range(0, 7));
        return AW'(32'h00010 + $urandom_range(0, 5));
    endfunction

    // One clock: observe results of the edge, update the model, drive the next inputs,
    // and predict what the next edge must do.
    task automatic step();
        word_t w;
        bit    hz;
        bit    m_ok;
        @(posedge clk);
        #1;
        // completion of the transaction acked during the previous cycle
        exp_m_ack = acking && txn_is_m;
        check("m_ack", m_ack, exp_m_ack);
        if (acking) begin
            s_ack  = 1'b0;
            acking = 0;
            check("s_access_drop", s_access, 1'b0);
            if (txn_is_m) begin
                if (!m_cur.wr) check("m_rdata", m_data_in, m_exp_rdata);
                else ref_mem[int'(m_cur.addr)] = merge(ref_rd(int'(m_cur.addr)), m_cur.data, m_cur.be);
                last_rd  = m_data_in;
                m_access = 1'b0;
            end else if (q.size() > 0) begin
                w = q.pop_front();
                ref_mem[int'(w.addr)] = merge(ref_rd(int'(w.addr)), w.data, w.be);
            end
            txn_active = 0;
        end
        // victim accept
        check("vwb_ack", vwb_ack, exp_vwb_ack);
        if (vwb_ack && exp_vwb_ack) begin
            q.push_back(vwb_cur);
            vwb_access = 1'b0;
        end
        // SDRAM port issue / hold
        if (txn_active) begin
            check("s_hold", {s_access, s_wr_en, s_addr, s_data_out, s_bytesel}, {1'b1, txn_bits});
        end else begin
            check("s_issue", s_access, exp_issue != K_NONE);
            if (s_access) begin
                txn_active = 1;
                txn_is_m   = (exp_issue == K_M);
                txn_bits   = {s_wr_en, s_addr, s_data_out, s_bytesel};
                lat        = $urandom_range(lat_min, lat_max);
                if (exp_issue == K_M) begin
                    check("m_issue", txn_bits, {m_cur.wr, m_cur.addr, m_cur.data, m_cur.be});
                    m_exp_rdata = ref_rd(int'(m_cur.addr));
                end else if (q.size() > 0) begin
                    check("drain_issue", txn_bits, {1'b1, q[0].addr, q[0].data, q[0].be});
                end
            end
        end
        check("wb_count", wb_count, q.size());
        check("wb_empty", wb_empty, (q.size() == 0) && !(txn_active && !txn_is_m));
        // SDRAM responder
        s_data_in = 16'($urandom);
        if (txn_active) begin
            if (lat == 0) begin
                s_ack     = 1'b1;
                acking    = 1;
                s_data_in = sdram_rd(int'(s_addr));
                if (s_wr_en) sdram_mem[int'(s_addr)] = merge(sdram_rd(int'(s_addr)), s_data_out, s_bytesel);
            end else begin
                lat--;
            end
        end
        // new requests
        if (!vwb_access) begin
            if (dq_vwb.size() > 0) begin
                vwb_cur = dq_vwb.pop_front();
                vwb_access = 1'b1;
            end else if (gen_en && ($urandom_range(0, 99) < vwb_rate)) begin
                vwb_cur = '{pick_addr(), 16'($urandom), 2'($urandom)};
                vwb_access = 1'b1;
            end
            vwb_addr     = vwb_cur.addr;
            vwb_data_out = vwb_cur.data;
            vwb_bytesel  = vwb_cur.be;
            vwb_wr_en    = 1'b1;
        end
        if (!m_access) begin
            if (dq_m.size() > 0) begin
                m_cur = dq_m.pop_front();
                m_access = 1'b1;
            end else if (gen_en && ($urandom_range(0, 99) < m_rate)) begin
                m_cur = '{1'($urandom), pick_addr(), 16'($urandom), 2'($urandom)};
                m_access = 1'b1;
            end
            m_addr     = m_cur.addr;
            m_data_out = m_cur.data;
            m_bytesel  = m_cur.be;
            m_wr_en    = m_cur.wr;
        end
        // predictions for the next edge
        hz = 0;
        foreach (q[i]) if (q[i].addr == m_addr) hz = 1;
        if (vwb_access && !exp_vwb_ack && (vwb_addr == m_addr)) hz = 1;
        m_ok = m_access && !exp_m_ack && !hz;
        if (txn_active)            exp_issue = K_NONE;
        else if (q.size() == DEPTH) exp_issue = K_DRAIN;
        else if (m_ok)             exp_issue = K_M;
        else if (q.size() > 0)     exp_issue = K_DRAIN;
        else                       exp_issue = K_NONE;
        exp_vwb_ack = vwb_access && !exp_vwb_ack && (q.size() < DEPTH);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic settle();
        int k;
        gen_en = 0;
        k = 0;
        while ((q.size() > 0 || txn_active || vwb_access || m_access ||
                dq_vwb.size() > 0 || dq_m.size() > 0) && k < 1000) begin
            step();
            k++;
        end
        check("settle_in_time", k < 1000, 1'b1);
        run(2);
    endtask

    task automatic wait_vwb_done();
        int k;
        k = 0;
        while ((dq_vwb.size() > 0 || vwb_access) && k < 200) begin
            step();
            k++;
        end
        check("vwb_accept_in_time", k < 200, 1'b1);
    endtask

    task automatic reset_mid_drain();
        int k;
        gen_en  = 1;
        lat_min = 3;
        lat_max = 8;
        k = 0;
        while (!(txn_active && !txn_is_m && !acking) && k < 500) begin
            step();
            k++;
        end
        check("rst_found_drain", s_access, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_s_access", s_access, 1'b0);
        check("rst_vwb_ack", vwb_ack, 1'b0);
        check("rst_m_ack", m_ack, 1'b0);
        check("rst_wb_count", wb_count, 0);
        check("rst_wb_empty", wb_empty, 1'b1);
        q.delete();
        txn_active = 0;
        acking     = 0;
        s_ack      = 1'b0;
        vwb_access = 1'b0;
        m_access   = 1'b0;
        exp_vwb_ack = 0;
        exp_m_ack   = 0;
        exp_issue   = K_NONE;
        gen_en      = 0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        lat_min = 0;
        lat_max = 4;
        dq_vwb.push_back('{19'h00015, 16'h5A5A, 2'b11});
        settle();
        check("post_rst_mem", sdram_rd(32'h15), 16'h5A5A);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sdram_mem[32'h12]   = 16'h1111;
        ref_mem[32'h12]     = 16'h1111;
        sdram_mem[32'h8010] = 16'h1111;
        ref_mem[32'h8010]   = 16'h1111;
        #1;
        check("reset_s_access", s_access, 1'b0);
        check("reset_vwb_ack", vwb_ack, 1'b0);
        check("reset_m_ack", m_ack, 1'b0);
        check("reset_m_data_in", m_data_in, 16'h0);
        check("reset_s_addr", s_addr, 0);
        check("reset_wb_count", wb_count, 0);
        check("reset_wb_empty", wb_empty, 1'b1);
        #11 reset_n = 1'b1;

        // single victim word
        dq_vwb.push_back('{19'h00010, 16'hDEAD, 2'b11});
        settle();
        check("single_mem", sdram_rd(32'h10), 16'hDEAD);

        // hazard: read of a buffered word waits for the drains
        dq_vwb.push_back('{19'h00010, 16'hDEAD, 2'b11});
        dq_vwb.push_back('{19'h00011, 16'hBEEF, 2'b11});
        wait_vwb_done();
        dq_m.push_back('{1'b0, 19'h00011, 16'h0000, 2'b11});
        settle();
        check("hazard_rdata", last_rd, 16'hBEEF);

        // unrelated read goes ahead of the pending drain
        dq_vwb.push_back('{19'h00010, 16'hC0DE, 2'b11});
        dq_m.push_back('{1'b0, 19'h08010, 16'h0000, 2'b11});
        settle();
        check("nohazard_rdata", last_rd, 16'h1111);

        // byte enables
        dq_vwb.push_back('{19'h00012, 16'hABCD, 2'b01});
        settle();
        check("be_low_mem", sdram_rd(32'h12), 16'h11CD);
        dq_m.push_back('{1'b1, 19'h00012, 16'h7755, 2'b10});
        settle();
        check("be_high_mem", sdram_rd(32'h12), 16'h77CD);

        // full buffer with a stalled SDRAM
        lat_min = 30;
        lat_max = 30;
        for (int i = 0; i < 5; i++) dq_vwb.push_back('{AW'(32'h20010 + i), 16'(16'hA000 + i), 2'b11});
        settle();
        for (int i = 0; i < 5; i++) check("full_mem", sdram_rd(32'h20010 + i), 16'(16'hA000 + i));

        // random traffic, normal and stalled SDRAM
        lat_min = 0; lat_max = 4; vwb_rate = 30; m_rate = 25; gen_en = 1;
        run(800);
        lat_min = 5; lat_max = 25; vwb_rate = 90; m_rate = 10;
        run(600);
        settle();

        reset_mid_drain();

        lat_min = 0; lat_max = 3; vwb_rate = 50; m_rate = 40; gen_en = 1;
        run(600);
        settle();

        foreach (ref_mem[a]) check("final_mem", sdram_rd(a), ref_mem[a]);
        foreach (sdram_mem[a]) check("final_extra", sdram_mem[a], ref_rd(a));
        check("final_empty", wb_empty, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
